mem_dbus_wb: RTL and testbench
==============================

// Module: mem_dbus_wb
// PURPOSE
//  Data-bus master between the MEM stage's data-memory port and the system Wishbone B4 classic bus.
//  - Turns each MEM-stage access (ce/we/addr/sel/data) into exactly one WB cycle.
//  - Raises a pipeline stall request until the access completes.
//  - Returns read data to MEM on mem_data_i. Byte lanes are big-endian and pass through unchanged:
//    sel[3] = data[31:24] = addr[1:0] 00.
//  - Sits between mem and the WB interconnect; stallreq_o goes to ctrl.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in BUSY without ack/err before a bus error is declared (1..255)
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  rst             in   1   asynchronous, active-low reset
//  cpu_ce_i        in   1   MEM access request (mem_ce_o)
//  cpu_we_i        in   1   write, already masked by exceptions (mem_we_o)
//  cpu_addr_i      in   32  byte address (mem_addr_o)
//  cpu_sel_i       in   4   byte lanes (mem_sel_o)
//  cpu_data_i      in   32  store data (mem_data_o)
//  cpu_data_o      out  32  load data to MEM (mem_data_i)
//  mem_stall_i     in   1   ctrl holds MEM stage this cycle
//  flush_i         in   1   ctrl pipeline flush (exception/mret)
//  stallreq_o      out  1   stall request to ctrl
//  bus_err_o       out  1   1-cycle pulse: access ended by wb_err_i or timeout
//  wb_adr_o        out  32  WB address, {cpu_addr_i[31:2],2'b00}
//  wb_dat_o        out  32  WB write data
//  wb_dat_i        in   32  WB read data
//  wb_sel_o        out  4   WB byte select
//  wb_we_o         out  1   WB write enable
//  wb_stb_o        out  1   WB strobe
//  wb_cyc_o        out  1   WB cycle
//  wb_ack_i        in   1   WB acknowledge
//  wb_err_i        in   1   WB error
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. All wb_* outputs, cpu_data_o, stallreq_o, bus_err_o and the timeout
//   counter are 0. A reset mid-cycle drops cyc/stb immediately; no completion is reported.
//  FSM states: IDLE, BUSY, HOLD. WB outputs are registered; stallreq_o and cpu_data_o are combinational.
//  IDLE:
//   - cpu_ce_i=1 & flush_i=0: stallreq_o=1. At the edge, latch adr/dat/sel/we, set cyc=stb=1, clear
//     the counter, go to BUSY.
//   - cpu_ce_i=0 or flush_i=1: stallreq_o=0, cpu_data_o=0, stay in IDLE.
//  BUSY: counter increments each cycle. Priority of terminating events, highest first:
//   1. flush_i=1, no ack: stallreq_o=0. Next edge: cyc=stb=0, go to IDLE (abort via CYC negation).
//   2. wb_ack_i=1 (also when flush_i=1 in the same cycle):
//      - stallreq_o=0; cpu_data_o=wb_dat_i combinationally; wb_dat_i is captured into rd_buf.
//      - Next edge: cyc=stb=0. Go to HOLD if mem_stall_i=1, else IDLE. MEM advances on this edge.
//   3. wb_err_i=1, or counter reaches TIMEOUT_CYCLES:
//      - stallreq_o=0, cpu_data_o=0.
//      - Next edge: cyc=stb=0, bus_err_o=1 for exactly 1 cycle, then HOLD/IDLE by the same rule as 2.
//   4. Otherwise: stallreq_o=1, outputs held stable (WB rule: no change while stb=1 and no ack).
//  HOLD:
//   - cpu_data_o=rd_buf, stallreq_o=0, no bus cycle issued. This prevents re-issuing the same
//     instruction's access while another stage stalls.
//   - Go to IDLE at the first edge with mem_stall_i=0 or flush_i=1.
//  Minimum access latency is 2 cycles (request cycle plus ack cycle). Back-to-back accesses are
//   separated by at least one IDLE cycle with cyc=0.
//  Writes: cpu_data_o is don't-care but driven 0. Stores with cpu_we_i=0 due to an exception issue
//   as reads, consistent with the MEM-stage masking.
//  Counter width is 8 bits and saturates; it never wraps within one access.
// STRUCTURE
//  - State encodings (IDLE/BUSY/HOLD, 2 bits) and the WB widths go in shared defines.v.
//  - Single flat module, no sub-modules; the timeout counter is inline.
// TESTING
//  1. Read, ack after 3 cycles, addr 0x0000_1004, wb_dat_i=0xDEADBEEF:
//     stallreq_o=1 for 3 cycles, then 0 in the ack cycle with cpu_data_o=0xDEADBEEF;
//     wb_adr_o=0x0000_1004, sel=1111.
//  2. SB to addr ...03, sel 0001, data 0x5A5A5A5A, ack on first cycle:
//     one WB write with we=1, sel=0001; cyc drops next edge; exactly one cycle issued.
//  3. Ack while mem_stall_i=1 for 4 cycles, wb_dat_i=0x12345678:
//     HOLD for 4 cycles with cpu_data_o=0x12345678 and cyc=0; no second WB cycle.
//  4. flush_i in the 2nd BUSY cycle, no ack:
//     cyc=stb=0 next edge, IDLE, bus_err_o stays 0.
//     Same test with ack in that cycle: completes normally.
//  5. TIMEOUT_CYCLES=8, slave never acks:
//     cyc drops after 8 BUSY cycles; bus_err_o pulses once; cpu_data_o=0.
//     wb_err_i on cycle 2: same response at cycle 2.
//  6. rst=0 asserted asynchronously mid-BUSY:
//     cyc/stb/stallreq_o go to 0 without waiting for a clock edge; after release, the next
//     request starts cleanly in IDLE.

Source files
------------

// File: rtl/mem_dbus_wb_pkg.sv
// Shared types and widths for the MEM-stage Wishbone data-bus master.
package mem_dbus_wb_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int WB_DAT_W  = 32;
  localparam int WB_SEL_W  = 4;
  localparam int TMO_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_HOLD = 2'b10
  } dbus_state_e;

  // Saturating increment for the BUSY timeout counter; it never wraps.
  function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] v);
    if (v == {TMO_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mem_dbus_wb.sv
// MEM-stage data-bus master: one Wishbone B4 classic cycle per MEM access,
// pipeline stall request until completion, and a HOLD state that replays the
// captured load data while another stage keeps MEM frozen.
module mem_dbus_wb
  import mem_dbus_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [WB_ADR_W-1:0] cpu_addr_i,
  input  logic [WB_SEL_W-1:0] cpu_sel_i,
  input  logic [WB_DAT_W-1:0] cpu_data_i,
  output logic [WB_DAT_W-1:0] cpu_data_o,
  input  logic                mem_stall_i,
  input  logic                flush_i,
  output logic                stallreq_o,
  output logic                bus_err_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

  dbus_state_e                state_r;
  dbus_state_e                state_nxt_s;
  logic [TMO_CNT_W-1:0]       cnt_r;
  logic [WB_DAT_W-1:0]        rd_buf_r;
  logic [WB_DAT_W-1:0]        rdata_s;
  logic                       stall_s;
  logic                       start_s;
  logic                       ack_s;
  logic                       fail_s;
  logic                       abort_s;
  logic                       tmo_s;
  logic                       addr_lsb_unused_s;

  // The bus is word addressed; byte selection travels on wb_sel_o.
  assign addr_lsb_unused_s = ^cpu_addr_i[1:0];

  // cnt_r holds the number of BUSY cycles already completed, so the current
  // cycle is number cnt_r+1; time out on the TIMEOUT_CYCLES-th BUSY cycle.
  assign tmo_s = (sat_inc(cnt_r) >= TMO_LIMIT);

  // Next-state decode plus the combinational stall and load-data outputs.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    rdata_s     = 32'h0000_0000;
    start_s     = 1'b0;
    ack_s       = 1'b0;
    fail_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stall_s     = 1'b1;
          start_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_i && !wb_ack_i) begin
          // Abort by negating CYC; nothing is reported back to MEM.
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wb_ack_i) begin
          ack_s       = 1'b1;
          rdata_s     = wb_we_o ? 32'h0000_0000 : wb_dat_i;
          state_nxt_s = (mem_stall_i && !flush_i) ? ST_HOLD : ST_IDLE;
        end else if (wb_err_i || tmo_s) begin
          fail_s      = 1'b1;
          state_nxt_s = (mem_stall_i && !flush_i) ? ST_HOLD : ST_IDLE;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end
      end
      ST_HOLD: begin
        // Replay the completed access so MEM never re-issues it.
        rdata_s = rd_buf_r;
        if (!mem_stall_i || flush_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Reset forces the combinational outputs low without waiting for a clock.
  assign stallreq_o = rst & stall_s;
  assign cpu_data_o = rst ? rdata_s : 32'h0000_0000;

  // State register, Wishbone request registers, timeout counter and read buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {TMO_CNT_W{1'b0}};
      rd_buf_r  <= 32'h0000_0000;
      bus_err_o <= 1'b0;
      wb_adr_o  <= 32'h0000_0000;
      wb_dat_o  <= 32'h0000_0000;
      wb_sel_o  <= 4'b0000;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bus_err_o <= fail_s;
      if (start_s) begin
        wb_adr_o <= {cpu_addr_i[31:2], 2'b00};
        wb_dat_o <= cpu_data_i;
        wb_sel_o <= cpu_sel_i;
        wb_we_o  <= cpu_we_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
      end else if (abort_s || ack_s || fail_s) begin
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end else begin
        wb_stb_o <= wb_stb_o;
        wb_cyc_o <= wb_cyc_o;
      end
      if (state_r == ST_BUSY) begin
        cnt_r <= sat_inc(cnt_r);
      end else begin
        cnt_r <= {TMO_CNT_W{1'b0}};
      end
      if (ack_s || fail_s) begin
        rd_buf_r <= rdata_s;
      end else begin
        rd_buf_r <= rd_buf_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_dbus_wb.sv
// Directed self-checking bench for mem_dbus_wb (TIMEOUT_CYCLES = 8).
module tb_mem_dbus_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        mem_stall_i, flush_i, stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;

  int total  = 0;
  int passed = 0;

  mem_dbus_wb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_sel_i = 4'h0;
    cpu_data_i = 32'h0; mem_stall_i = 1'b0; flush_i = 1'b0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL rst_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (wb_stb_o !== 1'b0) $display("FAIL rst_stb got=%0b exp=0", wb_stb_o); else passed++;
    total++; if (stallreq_o !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", stallreq_o); else passed++;
    total++; if (bus_err_o !== 1'b0) $display("FAIL rst_buserr got=%0b exp=0", bus_err_o); else passed++;
    total++; if (wb_adr_o !== 32'h0) $display("FAIL rst_adr got=%h exp=0", wb_adr_o); else passed++;
    total++; if (cpu_data_o !== 32'h0) $display("FAIL rst_data got=%h exp=0", cpu_data_o); else passed++;
    rst = 1'b1;
    next_cycle();
  endtask

  // Read of 0x1004, slave acks in the third BUSY cycle.
  task automatic test_read();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_1004; cpu_sel_i = 4'hF;
    #1;
    total++; if (stallreq_o !== 1'b1) $display("FAIL rd_stall_req got=%0b exp=1", stallreq_o); else passed++;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL rd_cyc_req got=%0b exp=0", wb_cyc_o); else passed++;
    next_cycle();
    total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) $display("FAIL rd_ctl got=%b exp=110", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
    total++; if (wb_adr_o !== 32'h0000_1004) $display("FAIL rd_adr got=%h exp=00001004", wb_adr_o); else passed++;
    total++; if (wb_sel_o !== 4'hF) $display("FAIL rd_sel got=%b exp=1111", wb_sel_o); else passed++;
    total++; if (stallreq_o !== 1'b1) $display("FAIL rd_stall_b1 got=%0b exp=1", stallreq_o); else passed++;
    next_cycle();
    total++; if (stallreq_o !== 1'b1) $display("FAIL rd_stall_b2 got=%0b exp=1", stallreq_o); else passed++;
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    #1;
    total++; if (stallreq_o !== 1'b0) $display("FAIL rd_stall_ack got=%0b exp=0", stallreq_o); else passed++;
    total++; if (cpu_data_o !== 32'hDEAD_BEEF) $display("FAIL rd_data_ack got=%h exp=deadbeef", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL rd_cyc_end got=%b exp=00", {wb_cyc_o, wb_stb_o}); else passed++;
    total++; if (cpu_data_o !== 32'h0) $display("FAIL rd_data_idle got=%h exp=0", cpu_data_o); else passed++;
    total++; if (bus_err_o !== 1'b0) $display("FAIL rd_buserr got=%0b exp=0", bus_err_o); else passed++;
    next_cycle();
  endtask

  // Byte store to 0x2003, ack in the first BUSY cycle.
  task automatic test_write();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_2003; cpu_sel_i = 4'b0001;
    cpu_data_i = 32'h5A5A_5A5A;
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    #1;
    total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) $display("FAIL wr_ctl got=%b exp=111", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
    total++; if (wb_sel_o !== 4'b0001) $display("FAIL wr_sel got=%b exp=0001", wb_sel_o); else passed++;
    total++; if (wb_adr_o !== 32'h0000_2000) $display("FAIL wr_adr got=%h exp=00002000", wb_adr_o); else passed++;
    total++; if (wb_dat_o !== 32'h5A5A_5A5A) $display("FAIL wr_dat got=%h exp=5a5a5a5a", wb_dat_o); else passed++;
    total++; if (stallreq_o !== 1'b0) $display("FAIL wr_stall got=%0b exp=0", stallreq_o); else passed++;
    total++; if (cpu_data_o !== 32'h0) $display("FAIL wr_data got=%h exp=0", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL wr_cyc_drop got=%0b exp=0", wb_cyc_o); else passed++;
    next_cycle();
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL wr_single got=%0b exp=0", wb_cyc_o); else passed++;
  endtask

  // Ack while MEM is stalled: four HOLD cycles replay the load data.
  task automatic test_hold();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_3008; cpu_sel_i = 4'hF;
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678; mem_stall_i = 1'b1;
    #1;
    total++; if (cpu_data_o !== 32'h1234_5678) $display("FAIL hold_ack_data got=%h exp=12345678", cpu_data_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0; mem_stall_i = (i < 3);
      #1;
      total++; if (cpu_data_o !== 32'h1234_5678) $display("FAIL hold_data[%0d] got=%h exp=12345678", i, cpu_data_o); else passed++;
      total++; if (wb_cyc_o !== 1'b0) $display("FAIL hold_cyc[%0d] got=%0b exp=0", i, wb_cyc_o); else passed++;
      total++; if (stallreq_o !== 1'b0) $display("FAIL hold_stall[%0d] got=%0b exp=0", i, stallreq_o); else passed++;
    end
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL hold_no_reissue got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (cpu_data_o !== 32'h0) $display("FAIL hold_exit_data got=%h exp=0", cpu_data_o); else passed++;
    next_cycle();
  endtask

  // Flush in the second BUSY cycle, first without ack then with ack.
  task automatic test_flush();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_4000; cpu_sel_i = 4'hF;
    next_cycle();
    next_cycle();
    flush_i = 1'b1;
    #1;
    total++; if (stallreq_o !== 1'b0) $display("FAIL fl_stall got=%0b exp=0", stallreq_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL fl_cyc got=%b exp=00", {wb_cyc_o, wb_stb_o}); else passed++;
    total++; if (bus_err_o !== 1'b0) $display("FAIL fl_buserr got=%0b exp=0", bus_err_o); else passed++;
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_4004; cpu_sel_i = 4'hF;
    next_cycle();
    next_cycle();
    flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    #1;
    total++; if (cpu_data_o !== 32'hCAFE_F00D) $display("FAIL fl_ack_data got=%h exp=cafef00d", cpu_data_o); else passed++;
    total++; if (stallreq_o !== 1'b0) $display("FAIL fl_ack_stall got=%0b exp=0", stallreq_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL fl_ack_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (bus_err_o !== 1'b0) $display("FAIL fl_ack_buserr got=%0b exp=0", bus_err_o); else passed++;
    next_cycle();
  endtask

  // Timeout after 8 BUSY cycles, then wb_err_i in BUSY cycle 2.
  task automatic test_timeout();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_6000; cpu_sel_i = 4'hF; wb_dat_i = 32'hA5A5_A5A5;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      total++; if (stallreq_o !== (i < 8)) $display("FAIL tmo_stall[%0d] got=%0b exp=%0b", i, stallreq_o, (i < 8)); else passed++;
      total++; if (wb_cyc_o !== 1'b1) $display("FAIL tmo_cyc[%0d] got=%0b exp=1", i, wb_cyc_o); else passed++;
    end
    total++; if (cpu_data_o !== 32'h0) $display("FAIL tmo_data got=%h exp=0", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL tmo_cyc_drop got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (bus_err_o !== 1'b1) $display("FAIL tmo_buserr got=%0b exp=1", bus_err_o); else passed++;
    next_cycle();
    total++; if (bus_err_o !== 1'b0) $display("FAIL tmo_buserr_pulse got=%0b exp=0", bus_err_o); else passed++;
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_6004; cpu_sel_i = 4'hF; wb_dat_i = 32'hA5A5_A5A5;
    next_cycle();
    total++; if (stallreq_o !== 1'b1) $display("FAIL err_stall_b1 got=%0b exp=1", stallreq_o); else passed++;
    next_cycle();
    wb_err_i = 1'b1;
    #1;
    total++; if (stallreq_o !== 1'b0) $display("FAIL err_stall got=%0b exp=0", stallreq_o); else passed++;
    total++; if (cpu_data_o !== 32'h0) $display("FAIL err_data got=%h exp=0", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL err_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (bus_err_o !== 1'b1) $display("FAIL err_buserr got=%0b exp=1", bus_err_o); else passed++;
    next_cycle();
    total++; if (bus_err_o !== 1'b0) $display("FAIL err_buserr_pulse got=%0b exp=0", bus_err_o); else passed++;
  endtask

  // Two accesses in a row must be separated by an IDLE cycle with cyc low.
  task automatic test_back_to_back();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_7000; cpu_sel_i = 4'hF;
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
    next_cycle();
    wb_ack_i = 1'b0; cpu_addr_i = 32'h0000_7010;
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL b2b_gap_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (stallreq_o !== 1'b1) $display("FAIL b2b_gap_stall got=%0b exp=1", stallreq_o); else passed++;
    next_cycle();
    total++; if (wb_adr_o !== 32'h0000_7010) $display("FAIL b2b_adr got=%h exp=00007010", wb_adr_o); else passed++;
    wb_ack_i = 1'b1; wb_dat_i = 32'h3333_4444;
    #1;
    total++; if (cpu_data_o !== 32'h3333_4444) $display("FAIL b2b_data got=%h exp=33334444", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  // Asynchronous reset in the middle of a BUSY cycle, then a clean access.
  task automatic test_reset_mid();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_5000; cpu_sel_i = 4'hF;
    next_cycle();
    #3;
    rst = 1'b0;
    #1;
    total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL arst_cyc got=%b exp=00", {wb_cyc_o, wb_stb_o}); else passed++;
    total++; if (stallreq_o !== 1'b0) $display("FAIL arst_stall got=%0b exp=0", stallreq_o); else passed++;
    idle_inputs();
    next_cycle();
    #3;
    rst = 1'b1;
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_5008; cpu_sel_i = 4'hF;
    #1;
    total++; if (stallreq_o !== 1'b1) $display("FAIL arst_req_stall got=%0b exp=1", stallreq_o); else passed++;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL arst_req_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    next_cycle();
    total++; if (wb_adr_o !== 32'h0000_5008) $display("FAIL arst_adr got=%h exp=00005008", wb_adr_o); else passed++;
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    #1;
    total++; if (cpu_data_o !== 32'h0BAD_F00D) $display("FAIL arst_data got=%h exp=0badf00d", cpu_data_o); else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++; if (wb_cyc_o !== 1'b0) $display("FAIL arst_end_cyc got=%0b exp=0", wb_cyc_o); else passed++;
    total++; if (bus_err_o !== 1'b0) $display("FAIL arst_buserr got=%0b exp=0", bus_err_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_hold();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
